// File: rtl/window_loader.sv
// window_loader
//   Converts an RGB pixel stream (arriving in window order) to greyscale and
//   assembles 5x5 windows in two ping-pong banks. A completed window is handed
//   to the convolution core while the other bank is being filled.
//
//   Build option GREY_FAST_EN: when defined, greyscale is (R + 2G + B) >> 2
//   computed without multipliers; otherwise the weighted luma
//   (77R + 150G + 29B) >> 8 is used. Interface and timing do not change.
//
//   Handshakes: a transfer happens on a rising edge where both valid and
//   ready are high. Valid never depends on ready. Once win_valid is high,
//   win_valid and win_data hold until the transfer (a FULL bank is never
//   written). pix_ready is combinational from rst, flush and the write-bank
//   state.
//
//   dbg_state exposes {rsel, wsel, state[1], state[0]} for checkers.

module window_loader #(
    parameter int WINDOW_WIDTH  = 5,
    parameter int WINDOW_HEIGHT = 5,
    parameter int PIX_W         = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [23:0]                                 pix_data,
    input  logic                                        pix_valid,
    output logic                                        pix_ready,
    input  logic                                        flush,
    output logic [WINDOW_WIDTH*WINDOW_HEIGHT*PIX_W-1:0] win_data,
    output logic                                        win_valid,
    input  logic                                        win_ready,
    output logic [15:0]                                 win_count,
    output logic [5:0]                                  dbg_state
);

    localparam int N     = WINDOW_WIDTH * WINDOW_HEIGHT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int WIN_W = N * PIX_W;

    // Per-bank state encoding
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    logic [1:0][1:0]       state_q, state_d;
    logic                  wsel_q, wsel_d;
    logic                  rsel_q, rsel_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [15:0]           count_q, count_d;
    logic [1:0][WIN_W-1:0] bank_q;

    logic                  accept;
    logic                  handoff;
    logic                  last_pix;
    logic [7:0]            grey8;
    logic [PIX_W-1:0]      grey_pix;

    // ------------------------------------------------------------------
    // Greyscale conversion
    // ------------------------------------------------------------------
`ifdef GREY_FAST_EN
    logic [9:0] fast_sum;

    // Multiplier-free approximation: R + 2G + B fits in 10 bits (max 1020)
    always_comb begin
        fast_sum = {2'b00, pix_data[23:16]}
                 + {1'b0, pix_data[15:8], 1'b0}
                 + {2'b00, pix_data[7:0]};
        grey8    = fast_sum[9:2];
    end
`else
    logic [15:0] luma_sum;

    // Weighted luma; weights total 256 so the 16-bit sum peaks at 65280
    always_comb begin
        luma_sum = 16'(16'd77  * {8'd0, pix_data[23:16]})
                 + 16'(16'd150 * {8'd0, pix_data[15:8]})
                 + 16'(16'd29  * {8'd0, pix_data[7:0]});
        grey8    = luma_sum[15:8];
    end
`endif

    assign grey_pix = PIX_W'(grey8);

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign pix_ready = !rst && !flush && (state_q[wsel_q] != ST_FULL);
    assign win_valid = (state_q[rsel_q] == ST_FULL);
    assign win_data  = bank_q[rsel_q];
    assign win_count = count_q;
    assign dbg_state = {rsel_q, wsel_q, state_q[1], state_q[0]};

    assign accept   = pix_valid && pix_ready;
    assign handoff  = win_valid && win_ready;
    assign last_pix = (idx_q == IDX_LAST);

    // Next-state: write side (fill / flush) and read side (release) act on
    // different banks, so both may update state_d in the same cycle.
    always_comb begin
        state_d = state_q;
        wsel_d  = wsel_q;
        rsel_d  = rsel_q;
        idx_d   = idx_q;
        count_d = count_q;

        if (flush) begin
            // Only the write bank can be FILLING; FULL banks survive a flush
            if (state_q[wsel_q] == ST_FILLING) begin
                state_d[wsel_q] = ST_EMPTY;
            end
            idx_d = '0;
        end else if (accept) begin
            if (last_pix) begin
                state_d[wsel_q] = ST_FULL;
                wsel_d          = ~wsel_q;
                idx_d           = '0;
            end else begin
                state_d[wsel_q] = ST_FILLING;
                idx_d           = idx_q + IDX_W'(1);
            end
        end

        if (handoff) begin
            state_d[rsel_q] = ST_EMPTY;
            rsel_d          = ~rsel_q;
            count_d         = count_q + 16'd1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= {ST_EMPTY, ST_EMPTY};
            wsel_q  <= 1'b0;
            rsel_q  <= 1'b0;
            idx_q   <= '0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wsel_q  <= wsel_d;
            rsel_q  <= rsel_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    // Pixel storage: accepted greyscale value lands at bank[wsel][idx]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= '0;
        end else if (accept) begin
            bank_q[wsel_q][idx_q*PIX_W +: PIX_W] <= grey_pix;
        end
    end

endmodule

// File: tb/tb_window_loader.sv
// Directed bench for window_loader: reset discard, greyscale arithmetic,
// element ordering, back-pressure, flush and overlapped streaming.

module tb_window_loader;

    localparam int N  = 25;
    localparam int WW = N * 8;

`ifdef GREY_FAST_EN
    localparam logic [7:0] GREY_102030 = 8'h20;
`else
    localparam logic [7:0] GREY_102030 = 8'h1D;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [23:0]   pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic          flush = 1'b0;
    logic [WW-1:0] win_data;
    logic          win_valid;
    logic          win_ready = 1'b0;
    logic [15:0]   win_count;
    logic [5:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_handoff = 0;
    int n_accept = 0;
    int n_valid_cycles = 0;
    int n_stalls = 0;

    logic [WW-1:0] exp_q[$];

    window_loader dut (
        .clk       (clk),
        .rst       (rst),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .flush     (flush),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_count (win_count),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Window where every element is the same value
    function automatic logic [WW-1:0] flat_win(input logic [7:0] v);
        logic [WW-1:0] w;
        for (int e = 0; e < N; e++) w[e*8 +: 8] = v;
        return w;
    endfunction

    // Window whose element e is base + e
    function automatic logic [WW-1:0] ramp_win(input int base);
        logic [WW-1:0] w;
        for (int e = 0; e < N; e++) w[e*8 +: 8] = 8'(base + e);
        return w;
    endfunction

    // Scoreboard and activity counters, sampled on the active edge
    always @(posedge clk) begin
        if (!rst) begin
            if (pix_valid && pix_ready) n_accept++;
            if (pix_valid && !pix_ready && !flush) n_stalls++;
            if (win_valid) n_valid_cycles++;
            if (win_valid && win_ready) begin
                n_handoff++;
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 1, 0);
                end else begin
                    check("window_data", win_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pix_valid = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_handoff = 0;
        n_accept = 0;
        n_valid_cycles = 0;
        n_stalls = 0;
    endtask

    // Offer one pixel from a negedge and return at the negedge after acceptance
    task automatic push(input logic [23:0] d);
        int guard;
        guard = 0;
        pix_data = d;
        pix_valid = 1'b1;
        #1;
        while (!pix_ready && guard < 300) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!pix_ready) check("push_timeout", 1, 0);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic wait_handoff(input int target);
        int guard;
        guard = 0;
        while (n_handoff < target && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("handoff_reached", WW'(n_handoff >= target), 1);
    endtask

    initial begin : main
        int acc_before;

        // ---------------- Reset state ----------------
        #2;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_win_data", win_data, 0);
        check("rst_win_count", win_count, 0);
        do_reset();
        #1;
        check("post_rst_pix_ready", pix_ready, 1);
        check("post_rst_dbg", dbg_state, 0);

        // ---------------- Reset mid-window ----------------
        win_ready = 1'b1;
        for (int i = 0; i < 12; i++) push(24'hABCDEF);
        check("rst_mid_accepts", n_accept, 12);
        rst = 1'b1;
        #1;
        check("rst_mid_pix_ready", pix_ready, 0);
        check("rst_mid_win_valid", win_valid, 0);
        check("rst_mid_win_data", win_data, 0);
        @(negedge clk);
        rst = 1'b0;
        n_handoff = 0;
        n_valid_cycles = 0;
        exp_q.push_back(flat_win(8'hFF));
        for (int i = 0; i < N; i++) push(24'hFFFFFF);
        wait_handoff(1);
        @(negedge clk);
        check("rst_mid_count", win_count, 1);
        check("rst_mid_one_valid", n_valid_cycles, 1);

        // ---------------- Arithmetic ----------------
        exp_q.push_back(flat_win(GREY_102030));
        for (int i = 0; i < N; i++) push(24'h102030);
        wait_handoff(2);
        @(negedge clk);
        check("arith_count", win_count, 2);

        // ---------------- Ordering ----------------
        exp_q.push_back(ramp_win(0));
        for (int i = 0; i < N; i++) push({8'(i), 8'(i), 8'(i)});
        wait_handoff(3);
        @(negedge clk);
        check("order_count", win_count, 3);
        check("order_drain", exp_q.size(), 0);

        // ---------------- Back-pressure ----------------
        win_ready = 1'b0;
        do_reset();
        begin : bp
            int unstable;
            unstable = 0;
            for (int k = 0; k < 60; k++) begin
                if (win_valid && win_data !== ramp_win(0)) unstable++;
                pix_data = {8'(k), 8'(k), 8'(k)};
                pix_valid = 1'b1;
                @(negedge clk);
            end
            pix_valid = 1'b0;
            check("bp_unstable", unstable, 0);
        end
        #1;
        check("bp_accepts", n_accept, 50);
        check("bp_pix_ready", pix_ready, 0);
        check("bp_win_valid", win_valid, 1);
        check("bp_win_data_a", win_data, ramp_win(0));
        check("bp_count0", win_count, 0);
        exp_q.push_back(ramp_win(0));
        exp_q.push_back(ramp_win(25));
        @(negedge clk);
        win_ready = 1'b1;
        @(negedge clk);
        win_ready = 1'b0;
        #1;
        check("bp_count1", win_count, 1);
        check("bp_ready_back", pix_ready, 1);
        check("bp_second_valid", win_valid, 1);
        check("bp_win_data_b", win_data, ramp_win(25));
        @(negedge clk);
        win_ready = 1'b1;
        wait_handoff(2);
        @(negedge clk);
        check("bp_count2", win_count, 2);

        // ---------------- Flush ----------------
        do_reset();
        for (int i = 0; i < 10; i++) push(24'h070707);
        acc_before = n_accept;
        flush = 1'b1;
        pix_data = 24'hC8C8C8;
        pix_valid = 1'b1;
        #1;
        check("flush_pix_ready", pix_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        pix_valid = 1'b0;
        check("flush_no_accept", n_accept, acc_before);
        exp_q.push_back(ramp_win(100));
        for (int i = 0; i < N; i++) push({8'(100 + i), 8'(100 + i), 8'(100 + i)});
        wait_handoff(1);
        @(negedge clk);
        check("flush_count", win_count, 1);
        check("flush_drain", exp_q.size(), 0);

        // ---------------- Overlap ----------------
        do_reset();
        for (int w = 0; w < 10; w++) exp_q.push_back(ramp_win(w * 7));
        for (int w = 0; w < 10; w++) begin
            for (int e = 0; e < N; e++) begin
                push({8'(w * 7 + e), 8'(w * 7 + e), 8'(w * 7 + e)});
            end
        end
        wait_handoff(10);
        repeat (2) @(negedge clk);
        check("ovl_count", win_count, 10);
        check("ovl_stalls", n_stalls, 0);
        check("ovl_valid_cycles", n_valid_cycles, 10);
        check("ovl_accepts", n_accept, 250);
        check("ovl_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/window_loader.md
# window_loader

Pixel-to-window staging stage in front of the edge-detection core. It accepts 24-bit RGB pixels that arrive in window order from the bus read path: 25 pixels per 5x5 window, row-major, with successive windows stepping by WINDOW-2. It converts each pixel to 8-bit greyscale and assembles complete windows in two ping-pong banks. Full windows are handed to the convolution core over a valid/ready handshake, so loading of the next window overlaps consumption of the current one.

## Interface
- WINDOW_WIDTH, 5, pixels per window row
- WINDOW_HEIGHT, 5, pixels per window column
- PIX_W, 8, greyscale pixel width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pix_data  in  24  RGB pixel; R[23:16], G[15:8], B[7:0]
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  loader can accept a pixel this cycle
- flush  in  1  synchronous discard of the partially filled window
- win_data  out  WINDOW_WIDTH*WINDOW_HEIGHT*PIX_W  window; element (r,c) at bits [(r*WINDOW_WIDTH+c)*PIX_W +: PIX_W]
- win_valid  out  1  win_data holds a complete window
- win_ready  in  1  downstream consumes the window this cycle
- win_count  out  16  windows handed off since reset, wraps 65535->0

## Operation
- Storage:
  - Two banks of N = WINDOW_WIDTH*WINDOW_HEIGHT PIX_W-bit registers.
  - Per-bank state: EMPTY, FILLING, FULL.
  - Write bank select wsel, read bank select rsel, fill index idx in 0..N-1.
- Greyscale (default):
  - g = (77*R + 150*G + 29*B) >> 8.
  - Products summed in 16 bits. The weights sum to 256, so the maximum sum is 65280 and cannot overflow.
  - g = sum[15:8].
- Accept rule:
  - A pixel is accepted when pix_valid && pix_ready.
  - pix_ready = !rst && !flush && state[wsel] != FULL. It is combinational.
- On accept:
  - g is written to bank[wsel][idx].
  - bank[wsel] goes EMPTY->FILLING.
  - If idx == N-1: bank[wsel] goes to FULL, wsel toggles, idx = 0. Otherwise idx increments.
- Read side:
  - win_valid = state[rsel] == FULL.
  - win_data = bank[rsel].
- On win_valid && win_ready:
  - bank[rsel] goes to EMPTY, rsel toggles, win_count increments.
- Simultaneous last-pixel fill of one bank and release of the other: both take effect in the same cycle.
- A FULL bank is never written, so win_data is stable while win_valid is high.
- flush:
  - The FILLING bank goes to EMPTY and idx = 0.
  - FULL banks, rsel and win_count are untouched.
  - pix_ready is low in the flush cycle, so any offered pixel is not accepted.
- Reset values:
  - pix_ready 0 while rst is high, 1 after release.
  - win_valid 0, win_data all zeros, win_count 0.
  - Both banks EMPTY, wsel = rsel = 0, idx = 0.
- Reset mid-window: the partial window and any full windows are discarded, and no win_valid is produced for them.

## Timing
- Throughput: one pixel per cycle. A window completes N = 25 cycles after its first accept when pixels are unbroken.
- Latency: last pixel accepted at edge k → win_valid high from edge k (visible in cycle k+1). win_data is complete at the same time.
- Release: win_ready sampled high at edge k → win_valid reflects the other bank from edge k; a freed bank restores pix_ready in the same cycle.
- Back-pressure: with win_ready held low, at most 2*N pixels are accepted. pix_ready then stays low until a release.
- win_count updates at the handoff edge.

## Configuration
- GREY_FAST_EN defined: g = (R + 2*G + B) >> 2 computed in 10 bits, with no multipliers.
- GREY_FAST_EN undefined: weighted luma as above.
- The interface and timing are identical in both modes.

## Test plan
- Reset: assert rst after 12 pixels are accepted, release, feed 25 pixels 0xFFFFFF → exactly one win_valid, all elements 0xFF, win_count = 1.
- Arithmetic: 25 pixels 0x102030 → all elements 29 (0x1D) by default; 32 (0x20) with GREY_FAST_EN.
- Ordering: pixel i = {i,i,i} for i = 0..24 → element i equals i, i.e. r = i/5, c = i%5.
- Back-pressure: win_ready = 0, pix_valid held high with 60 pixels → 50 accepted, pix_ready low after the 50th, win_data constant. Pulse win_ready for one cycle → win_count = 1, pix_ready high in the same cycle, second window presented.
- Flush: flush after 10 pixels, then 25 pixels with values 100..124 → window element 0 = 100, element 24 = 124. A pixel offered in the flush cycle is not accepted.
- Overlap: win_ready high permanently, 250 unbroken pixels → 10 windows, pix_ready never low, win_valid pulses one cycle every 25 cycles, win_count = 10.
